// File: rtl/comp_div_seq.sv
// Sequential 8-bit restoring divider with registered dividend compensation flag.
// Define COMP_DIV_APPLY_EN to add the flag into the quotient (saturating at 255).
module comp_div_seq #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          comp,
  output logic          div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;     // dividend shifts out MSB-first, quotient bits shift in
  logic [DW-1:0] dvs_q, dvs_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] remo_q, remo_d;
  logic          comp_q, comp_d;
  logic          dz_q, dz_d;

  logic [DW:0]   trial;
  logic          qbit;
  logic [DW-1:0] rem_nxt;
  logic [DW-1:0] raw_q;

  function automatic logic comp_rule(input logic [7:0] d);
    if (d[7])      return d[3:0] >= 4'd9;
    else if (d[6]) return d[2:0] >= 3'd5;
    else if (d[5]) return d[1:0] == 2'b11;
    else           return 1'b0;
  endfunction

  // 9-bit partial remainder: a held remainder is always below the divisor,
  // so only the trial value needs the extra bit.
  assign trial   = {rem_q, dvd_q[DW-1]};
  assign qbit    = trial >= {1'b0, dvs_q};
  assign rem_nxt = qbit ? DW'(trial - {1'b0, dvs_q}) : trial[DW-1:0];
  assign raw_q   = {dvd_q[DW-2:0], qbit};

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = remo_q;
  assign comp      = comp_q;
  assign div_zero  = dz_q;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    comp_d  = comp_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          comp_d = comp_rule(dividend);
          if (divisor == '0) begin
            quo_d   = '1;
            remo_d  = dividend;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            cnt_d   = '0;
            dz_d    = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = rem_nxt;
        dvd_d = raw_q;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(DW-1)) begin
`ifdef COMP_DIV_APPLY_EN
          quo_d = (raw_q == '1) ? raw_q : raw_q + {{(DW-1){1'b0}}, comp_q};
`else
          quo_d = raw_q;
`endif
          remo_d  = rem_nxt;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      comp_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      comp_q  <= comp_d;
      dz_q    <= dz_d;
    end
  end

endmodule
